// File: rtl/johnson6_pkg.sv
// rtl/johnson6_pkg.sv - shared types, code points and helpers for the Johnson-6 phase monitor
package johnson6_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        FAULT  = 2'd2
    } state_t;

    // Legal codes in sequence order; phase index n corresponds to CODE_Pn.
    localparam logic [2:0] CODE_P0 = 3'd0;
    localparam logic [2:0] CODE_P1 = 3'd1;
    localparam logic [2:0] CODE_P2 = 3'd3;
    localparam logic [2:0] CODE_P3 = 3'd7;
    localparam logic [2:0] CODE_P4 = 3'd6;
    localparam logic [2:0] CODE_P5 = 3'd4;

    localparam logic [2:0] CODE_BAD_A = 3'd2;
    localparam logic [2:0] CODE_BAD_B = 3'd5;

    function automatic logic [2:0] succ(input logic [2:0] code);
        case (code)
            CODE_P0: succ = CODE_P1;
            CODE_P1: succ = CODE_P2;
            CODE_P2: succ = CODE_P3;
            CODE_P3: succ = CODE_P4;
            CODE_P4: succ = CODE_P5;
            default: succ = CODE_P0;
        endcase
    endfunction

    function automatic logic [2:0] phase_idx(input logic [2:0] code);
        case (code)
            CODE_P0: phase_idx = 3'd0;
            CODE_P1: phase_idx = 3'd1;
            CODE_P2: phase_idx = 3'd2;
            CODE_P3: phase_idx = 3'd3;
            CODE_P4: phase_idx = 3'd4;
            CODE_P5: phase_idx = 3'd5;
            default: phase_idx = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/johnson6_step.sv
// rtl/johnson6_step.sv - combinational decode of one Johnson-6 code: successor, phase, legality
module johnson6_step
    import johnson6_pkg::*;
(
    input  logic [2:0] code,
    output logic [2:0] next_code,
    output logic [5:0] onehot,
    output logic       legal
);

    always_comb begin
        next_code = succ(code);
        legal     = (code != CODE_BAD_A) && (code != CODE_BAD_B);
        onehot    = legal ? (6'b000001 << phase_idx(code)) : 6'b000000;
    end

endmodule

// File: rtl/johnson6_phase_monitor.sv
// rtl/johnson6_phase_monitor.sv - sequence checker producing phase strobes and revolution count
module johnson6_phase_monitor
    import johnson6_pkg::*;
#(
    parameter int CYCLE_W = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               en,
    input  logic               clr_i,
    input  logic [2:0]         cnt_i,
    output logic [5:0]         phase_o,
    output logic               cycle_done_o,
    output logic [CYCLE_W-1:0] cycle_cnt_o,
    output logic               locked_o,
    output logic               fault_o
);

    state_t             fsm;
    state_t             fsm_nxt;
    logic [2:0]         prev_q;
    logic [2:0]         prev_nxt;
    logic [5:0]         phase_nxt;
    logic               done_nxt;
    logic [CYCLE_W-1:0] cnt_nxt;

    logic [2:0] cnt_next_unused;
    logic [5:0] cnt_onehot;
    logic       cnt_legal;
    logic [2:0] prev_succ;
    logic [5:0] prev_onehot_unused;
    logic       prev_legal_unused;

    johnson6_step u_step_cnt (
        .code      (cnt_i),
        .next_code (cnt_next_unused),
        .onehot    (cnt_onehot),
        .legal     (cnt_legal)
    );

    johnson6_step u_step_prev (
        .code      (prev_q),
        .next_code (prev_succ),
        .onehot    (prev_onehot_unused),
        .legal     (prev_legal_unused)
    );

    logic legal_step;
    logic wrap_step;

    assign legal_step = cnt_legal && (cnt_i == prev_succ);
    assign wrap_step  = legal_step && (prev_q == CODE_P5);

    always_comb begin
        fsm_nxt   = fsm;
        prev_nxt  = prev_q;
        phase_nxt = phase_o;
        done_nxt  = 1'b0;
        cnt_nxt   = cycle_cnt_o;
        if (clr_i) begin
            fsm_nxt   = SEARCH;
            phase_nxt = '0;
            cnt_nxt   = '0;
        end else if (en) begin
            case (fsm)
                SEARCH: begin
                    if (cnt_i == CODE_P0) begin
                        fsm_nxt   = TRACK;
                        prev_nxt  = CODE_P0;
                        phase_nxt = cnt_onehot;
                    end else begin
                        phase_nxt = '0;
                    end
                end
                TRACK: begin
                    // A stall (cnt_i == prev_q) falls through with everything held.
                    if (legal_step) begin
                        prev_nxt  = cnt_i;
                        phase_nxt = cnt_onehot;
                        if (wrap_step) begin
                            done_nxt = 1'b1;
                            cnt_nxt  = cycle_cnt_o + CYCLE_W'(1);
                        end
                    end else if (cnt_i != prev_q) begin
                        fsm_nxt   = FAULT;
                        phase_nxt = '0;
                    end
                end
                FAULT: begin
                    phase_nxt = '0;
                end
                default: begin
                    fsm_nxt   = SEARCH;
                    phase_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fsm          <= SEARCH;
            prev_q       <= '0;
            phase_o      <= '0;
            cycle_done_o <= 1'b0;
            cycle_cnt_o  <= '0;
        end else begin
            fsm          <= fsm_nxt;
            prev_q       <= prev_nxt;
            phase_o      <= phase_nxt;
            cycle_done_o <= done_nxt;
            cycle_cnt_o  <= cnt_nxt;
        end
    end

    assign locked_o = (fsm == TRACK);
    assign fault_o  = (fsm == FAULT);

endmodule

// File: doc/johnson6_phase_monitor.md
# johnson6_phase_monitor

Downstream consumer of the 6-state Johnson sequence counter (0→1→3→7→6→4→0). Samples the counter value every clock and checks that it follows the legal sequence. Produces registered one-hot phase strobes, a once-per-revolution pulse and a wrapping revolution count for the control logic that follows. Locks onto the sequence at state 0 and latches a sticky fault on any illegal code or illegal transition.

## Interface
- CYCLE_W, 8, width of revolution counter
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- en  in  1  sample enable; 0 freezes all state and outputs
- clr_i  in  1  synchronous clear of fault, lock and revolution count
- cnt_i  in  3  counter value from the Johnson sequence counter
- phase_o  out  6  registered one-hot phase: bit0=0, bit1=1, bit2=3, bit3=7, bit4=6, bit5=4
- cycle_done_o  out  1  one-cycle pulse on each 4→0 transition while locked
- cycle_cnt_o  out  CYCLE_W  completed revolutions, wraps to 0
- locked_o  out  1  high in TRACK
- fault_o  out  1  high in FAULT (sticky)

## Operation
- Registered state: fsm (SEARCH, TRACK, FAULT), prev_q[2:0], phase_o, cycle_done_o, cycle_cnt_o.
- Reset values: fsm=SEARCH, prev_q=0, phase_o=0, cycle_done_o=0, cycle_cnt_o=0, locked_o=0, fault_o=0.
- Priority per edge: rstn > clr_i > en. clr_i=1 (en ignored): fsm→SEARCH, cycle_cnt_o→0, phase_o→0, cycle_done_o→0.
- en=0 and clr_i=0: every register holds, except cycle_done_o, which is forced to 0.
- SEARCH: phase_o=0.
  - cnt_i==0: go to TRACK, prev_q←0, phase_o←000001.
  - Any other code, including illegal 2 and 5: stay in SEARCH. No fault is raised.
- TRACK, three cases:
  - Legal step, cnt_i==succ(prev_q): prev_q←cnt_i, phase_o←onehot(cnt_i).
  - Stall, cnt_i==prev_q: legal. Registers unchanged, cycle_done_o←0.
  - Anything else, including codes 2 or 5: go to FAULT, phase_o←0.
- Revolution: a legal step 4→0 in TRACK sets cycle_done_o←1 and cycle_cnt_o←cycle_cnt_o+1 modulo 2^CYCLE_W. cycle_done_o is 0 on every other edge.
- FAULT: phase_o=0, cycle_done_o=0, cycle_cnt_o holds. Exit only via clr_i or rstn.
- locked_o = (fsm==TRACK). fault_o = (fsm==FAULT). Both are decoded directly from the state register (no glitches).

## Timing
- One-cycle latency: cnt_i sampled at edge k appears on phase_o, cycle_done_o and cycle_cnt_o after edge k.
- Block shares rstn with the counter:
  - First edge after reset release samples cnt_i=0 → TRACK, phase_o=000001.
  - Free-running counter then yields one phase bit per cycle: 000001, 000010, 000100, 001000, 010000, 100000, repeat.
  - cycle_done_o pulses every 6th cycle.
- Reset asserted mid-sequence: all outputs clear immediately (asynchronous). Relock occurs on the first edge after release.
- clr_i in the same cycle as a fault-causing input: clear wins, fsm=SEARCH.
- cycle_cnt_o at 2^CYCLE_W−1 plus one revolution → 0, with cycle_done_o still pulsing.

## Structure
- Package johnson6_pkg:
  - state enum {SEARCH, TRACK, FAULT}
  - localparams for the six legal codes and the two illegal codes (2, 5)
  - function succ(code)
  - function phase_idx(code)
- Sub-module johnson6_step: purely combinational, input code[2:0]; outputs next_code[2:0], onehot[5:0], legal.
  - Instantiated once on cnt_i (phase decode, legality).
  - Instantiated once on prev_q (expected successor).
- Top level holds the FSM, the registers and the revolution counter.

## Test plan
- Reset, then cnt_i driven 0,1,3,7,6,4,0,1 on consecutive edges:
  - phase_o walks bit0..bit5 then bit0, one cycle after each sample.
  - cycle_done_o pulses once, after the 4→0 edge; cycle_cnt_o=1; locked_o=1.
- Start in SEARCH with cnt_i=3 then 5 for 4 cycles:
  - locked_o=0, fault_o=0, phase_o=0.
  - Then cnt_i=0 → locked_o=1, phase_o=000001.
- Locked at 7, then cnt_i=3 (illegal backward step):
  - fault_o=1, phase_o=0, persists 10 cycles.
  - clr_i pulse → fault_o=0, locked_o=0, cycle_cnt_o=0.
- Locked, cnt_i held at 6 for 3 cycles, then 4: no fault, phase_o stays 010000, then 100000. Repeat with en=0 for 3 cycles while cnt_i changes: all outputs frozen.
- CYCLE_W=2, 5 full revolutions: cycle_cnt_o = 1,2,3,0,1; cycle_done_o pulses 5 times.
- rstn pulled low mid-revolution (at cnt 7), released with cnt_i=0: outputs zero during reset; phase_o=000001 on first edge after release.
